// File: rtl/team_06_channel_arbiter_if.sv
// Signal bundle between the front end / datapath and the channel arbiter.
interface team_06_channel_arbiter_if;
   logic       sample_tick;
   logic       ptt_en;
   logic       vox_active;
   logic       ng_on;
   logic       spk_active;
   logic       mute_tog;
   logic [2:0] eff_sel;
   logic       tx_en;
   logic       rx_en;
   logic       effect_en;
   logic [2:0] eff_cfg;
   logic       eff_flush;
   logic [2:0] state_o;

   // Front end / bench side: drives requests, observes enables.
   modport master (
      output sample_tick, ptt_en, vox_active, ng_on, spk_active, mute_tog, eff_sel,
      input  tx_en, rx_en, effect_en, eff_cfg, eff_flush, state_o
   );

   // Arbiter side.
   modport slave (
      input  sample_tick, ptt_en, vox_active, ng_on, spk_active, mute_tog, eff_sel,
      output tx_en, rx_en, effect_en, eff_cfg, eff_flush, state_o
   );
endinterface

// File: rtl/team_06_channel_arbiter.sv
// Half-duplex channel arbiter: RX/TX ownership with VOX hangover and
// turnaround guard (counted in audio samples), plus an effect-change
// sequencer that blanks the effect datapath for a flush window.
module team_06_channel_arbiter #(
   parameter int HANG_SAMPLES  = 4000,
   parameter int GUARD_SAMPLES = 80,
   parameter int FLUSH_SAMPLES = 16,
   parameter int CNT_W         = 16
) (
   input logic                         clk,
   input logic                         rst,
   team_06_channel_arbiter_if.slave    bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RX    = 3'd1,
      ST_TX    = 3'd2,
      ST_HANG  = 3'd3,
      ST_GUARD = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] HANG_LOAD  = CNT_W'(HANG_SAMPLES);
   localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_SAMPLES);
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_SAMPLES);

   state_t           r_state, w_state_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic [2:0]       r_eff_cfg, w_eff_cfg_next;
   logic [2:0]       r_target, w_target_next;
   logic [CNT_W-1:0] r_fcnt, w_fcnt_next;
   logic             r_flush, w_flush_next;

   logic w_tx_req;
   logic w_sel_valid;

   assign w_tx_req    = bus.ptt_en | (bus.ng_on & bus.vox_active);
   assign w_sel_valid = (bus.eff_sel <= 3'd4);

   // State and counter registers; reset overrides any tick in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_eff_cfg <= 3'd0;
         r_target  <= 3'd0;
         r_fcnt    <= '0;
         r_flush   <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_eff_cfg <= w_eff_cfg_next;
         r_target  <= w_target_next;
         r_fcnt    <= w_fcnt_next;
         r_flush   <= w_flush_next;
      end
   end

   // Channel FSM next-state: hang/guard countdowns advance only on sample ticks.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (bus.spk_active)  w_state_next = ST_RX;
            else if (w_tx_req)   w_state_next = ST_TX;
         end
         ST_RX: begin
            if (!bus.spk_active) begin
               w_state_next = ST_GUARD;
               w_cnt_next   = GUARD_LOAD;
            end
         end
         ST_TX: begin
            if (!w_tx_req) begin
               if (bus.ng_on) begin
                  w_state_next = ST_HANG;
                  w_cnt_next   = HANG_LOAD;
               end else begin
                  w_state_next = ST_GUARD;
                  w_cnt_next   = GUARD_LOAD;
               end
            end
         end
         ST_HANG: begin
            // Renewed talk request beats expiry in the same cycle.
            if (w_tx_req) begin
               w_state_next = ST_TX;
               w_cnt_next   = '0;
            end else if (!bus.ng_on) begin
               w_state_next = ST_GUARD;
               w_cnt_next   = GUARD_LOAD;
            end else if (bus.sample_tick) begin
               if (r_cnt <= CNT_W'(1)) begin
                  w_state_next = ST_GUARD;
                  w_cnt_next   = GUARD_LOAD;
               end else begin
                  w_cnt_next = r_cnt - CNT_W'(1);
               end
            end
         end
         ST_GUARD: begin
            if (bus.sample_tick) begin
               if (r_cnt <= CNT_W'(1)) begin
                  w_state_next = ST_IDLE;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt - CNT_W'(1);
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_cnt_next   = '0;
         end
      endcase
   end

   // Effect sequencer: RUN when r_flush=0, FLUSH when r_flush=1.
   always_comb begin
      w_eff_cfg_next = r_eff_cfg;
      w_target_next  = r_target;
      w_fcnt_next    = r_fcnt;
      w_flush_next   = r_flush;
      if (!r_flush) begin
         if (w_sel_valid && (bus.eff_sel != r_eff_cfg)) begin
            w_target_next = bus.eff_sel;
            w_fcnt_next   = FLUSH_LOAD;
            w_flush_next  = 1'b1;
         end
      end else if (w_sel_valid && (bus.eff_sel != r_target)) begin
         // A different request mid-flush restarts the window on the new target.
         w_target_next = bus.eff_sel;
         w_fcnt_next   = FLUSH_LOAD;
      end else if (bus.sample_tick) begin
         if (r_fcnt <= CNT_W'(1)) begin
            w_eff_cfg_next = r_target;
            w_fcnt_next    = '0;
            w_flush_next   = 1'b0;
         end else begin
            w_fcnt_next = r_fcnt - CNT_W'(1);
         end
      end
   end

   // Outputs decoded from registered state only (mute gates the speaker directly).
   assign bus.tx_en     = (r_state == ST_TX) || (r_state == ST_HANG);
   assign bus.rx_en     = (r_state == ST_RX) && !bus.mute_tog;
   assign bus.effect_en = ((r_state == ST_TX) || (r_state == ST_HANG)) && !r_flush;
   assign bus.eff_cfg   = r_eff_cfg;
   assign bus.eff_flush = r_flush;
   assign bus.state_o   = r_state;

endmodule

// File: tb/tb_team_06_channel_arbiter.sv
// Directed bench for the channel arbiter with a small expected-output queue.
module tb_team_06_channel_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   logic [9:0] exp_q[$];
   string      tag_q[$];

   team_06_channel_arbiter_if bus ();

   team_06_channel_arbiter #(
      .HANG_SAMPLES (4),
      .GUARD_SAMPLES(2),
      .FLUSH_SAMPLES(3),
      .CNT_W        (16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Pack {state, tx, rx, effect_en, cfg, flush}.
   function automatic logic [9:0] pk(input int st, input bit tx, input bit rx,
                                     input bit een, input int cfg, input bit fl);
      return {3'(st), tx, rx, een, 3'(cfg), fl};
   endfunction

   // One clock: push expectation, drive tick, compare after the edge.
   task automatic cyc(input bit tk, input string tag, input logic [9:0] exp);
      logic [9:0] got, want;
      string      t;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      bus.sample_tick = tk;
      @(posedge clk);
      #1;
      bus.sample_tick = 1'b0;
      got  = {bus.state_o, bus.tx_en, bus.rx_en, bus.effect_en, bus.eff_cfg, bus.eff_flush};
      want = exp_q.pop_front();
      t    = tag_q.pop_front();
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s got=%b exp=%b", t, got, want);
      end
      $display("step %-12s st=%0d tx=%b rx=%b een=%b cfg=%0d fl=%b", t,
               bus.state_o, bus.tx_en, bus.rx_en, bus.effect_en, bus.eff_cfg, bus.eff_flush);
   endtask

   initial begin
      bus.sample_tick = 0; bus.ptt_en = 0; bus.vox_active = 0; bus.ng_on = 0;
      bus.spk_active = 0; bus.mute_tog = 0; bus.eff_sel = 3'd0;
      rst = 1'b1;
      cyc(0, "rst", pk(0,0,0,0,0,0));
      cyc(1, "rst_tick", pk(0,0,0,0,0,0));

      // PTT transmit, release without VOX -> guard -> idle after 2 ticks
      rst = 1'b0; bus.ptt_en = 1;
      cyc(0, "ptt_tx", pk(2,1,0,1,0,0));
      cyc(0, "tx_hold", pk(2,1,0,1,0,0));
      bus.ptt_en = 0;
      cyc(0, "guard", pk(4,0,0,0,0,0));
      cyc(0, "guard_notk", pk(4,0,0,0,0,0));
      cyc(1, "guard_t1", pk(4,0,0,0,0,0));
      cyc(1, "guard_t2", pk(0,0,0,0,0,0));

      // VOX hangover, re-trigger, then full expiry
      bus.ng_on = 1; bus.vox_active = 1;
      cyc(0, "vox_tx", pk(2,1,0,1,0,0));
      bus.vox_active = 0;
      cyc(0, "hang", pk(3,1,0,1,0,0));
      cyc(1, "hang_t1", pk(3,1,0,1,0,0));
      cyc(1, "hang_t2", pk(3,1,0,1,0,0));
      bus.vox_active = 1;
      cyc(0, "hang_retx", pk(2,1,0,1,0,0));
      bus.vox_active = 0;
      cyc(0, "hang2", pk(3,1,0,1,0,0));
      cyc(1, "hang2_t1", pk(3,1,0,1,0,0));
      cyc(1, "hang2_t2", pk(3,1,0,1,0,0));
      cyc(1, "hang2_t3", pk(3,1,0,1,0,0));
      cyc(1, "hang2_t4", pk(4,0,0,0,0,0));
      cyc(1, "hguard_t1", pk(4,0,0,0,0,0));
      cyc(1, "hguard_t2", pk(0,0,0,0,0,0));

      // ng_on dropping during hang goes straight to guard
      bus.vox_active = 1;
      cyc(0, "vox_tx2", pk(2,1,0,1,0,0));
      bus.vox_active = 0;
      cyc(0, "hang3", pk(3,1,0,1,0,0));
      bus.ng_on = 0;
      cyc(0, "ng_drop", pk(4,0,0,0,0,0));
      cyc(1, "ngg_t1", pk(4,0,0,0,0,0));
      cyc(1, "ngg_t2", pk(0,0,0,0,0,0));

      // Speaker wins over PTT; mute gates rx_en
      bus.spk_active = 1; bus.ptt_en = 1;
      cyc(0, "rx_win", pk(1,0,1,0,0,0));
      cyc(0, "rx_ptt_ign", pk(1,0,1,0,0,0));
      bus.mute_tog = 1;
      cyc(0, "rx_mute", pk(1,0,0,0,0,0));
      bus.mute_tog = 0; bus.spk_active = 0;
      cyc(0, "rx_guard", pk(4,0,0,0,0,0));
      cyc(1, "rxg_t1", pk(4,0,0,0,0,0));
      cyc(1, "rxg_t2", pk(0,0,0,0,0,0));

      // Effect change during TX
      cyc(0, "eff_tx", pk(2,1,0,1,0,0));
      bus.eff_sel = 3'd2;
      cyc(0, "fl_start", pk(2,1,0,0,0,1));
      cyc(1, "fl_t1", pk(2,1,0,0,0,1));
      cyc(1, "fl_t2", pk(2,1,0,0,0,1));
      cyc(1, "fl_t3", pk(2,1,0,1,2,0));
      bus.eff_sel = 3'd0;
      cyc(0, "fl2_start", pk(2,1,0,0,2,1));
      cyc(1, "fl2_t1", pk(2,1,0,0,2,1));
      bus.eff_sel = 3'd3;
      cyc(0, "fl2_relatch", pk(2,1,0,0,2,1));
      cyc(1, "fl2_r1", pk(2,1,0,0,2,1));
      cyc(1, "fl2_r2", pk(2,1,0,0,2,1));
      cyc(1, "fl2_r3", pk(2,1,0,1,3,0));
      bus.eff_sel = 3'd6;
      cyc(0, "eff_inval", pk(2,1,0,1,3,0));
      cyc(1, "eff_inval2", pk(2,1,0,1,3,0));

      // Reset mid-HANG and mid-FLUSH
      bus.eff_sel = 3'd1;
      cyc(0, "fl3_start", pk(2,1,0,0,3,1));
      bus.ptt_en = 0; bus.ng_on = 1; bus.vox_active = 0;
      cyc(0, "hang_fl", pk(3,1,0,0,3,1));
      rst = 1'b1;
      cyc(1, "rst_mid", pk(0,0,0,0,0,0));
      cyc(1, "rst_mid2", pk(0,0,0,0,0,0));
      rst = 1'b0; bus.eff_sel = 3'd0; bus.ng_on = 0;
      cyc(1, "post_rst", pk(0,0,0,0,0,0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
